// File: rtl/multi_zone_irrigation_ctrl.sv
// Multi-zone irrigation controller: one hysteresis FSM per zone, each with its own
// on-time/cooldown counter, plus a lowest-index-first arbiter capping concurrent pumps.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | pump off, requests when enabled and sensor < LOW_TH
// WATER    | pump on, counter tracks on-time (MIN_ON / MAX_ON bounds)
// COOLDOWN | pump off, counts COOLDOWN cycles, enable ignored
// FAULT    | sticky timeout, cleared only by enable low or reset
module multi_zone_irrigation_ctrl #(
    parameter int ZONES      = 4,
    parameter int SW         = 4,
    parameter int LOW_TH     = 4,
    parameter int HIGH_TH    = 10,
    parameter int MIN_ON     = 20,
    parameter int MAX_ON     = 200,
    parameter int COOLDOWN   = 50,
    parameter int MAX_ACTIVE = 2,
    parameter int CW         = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ZONES*SW-1:0]   sensor,
    input  logic [ZONES-1:0]      enable,
    output logic [ZONES-1:0]      pump,
    output logic [ZONES-1:0]      fault,
    output logic                  busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WATER = 2'd1;
    localparam logic [1:0] ST_COOL  = 2'd2;
    localparam logic [1:0] ST_FAULT = 2'd3;

    localparam logic [SW-1:0] LOW_V     = SW'(LOW_TH);
    localparam logic [SW-1:0] HIGH_V    = SW'(HIGH_TH);
    localparam logic [CW-1:0] MIN_LAST  = CW'(MIN_ON - 1);
    localparam logic [CW-1:0] MAX_LAST  = CW'(MAX_ON - 1);
    localparam logic [CW-1:0] COOL_LAST = CW'(COOLDOWN - 1);

    logic [1:0]    state_q [ZONES];
    logic [1:0]    state_d [ZONES];
    logic [CW-1:0] cnt_q   [ZONES];
    logic [CW-1:0] cnt_d   [ZONES];
    logic [SW-1:0] sens    [ZONES];
    int            active_c;
    int            granted_c;

    for (genvar g = 0; g < ZONES; g++) begin : g_zone
        assign sens[g]  = sensor[g*SW +: SW];
        assign pump[g]  = (state_q[g] == ST_WATER);
        assign fault[g] = (state_q[g] == ST_FAULT);
    end

    assign busy = |pump;

    always_comb begin
        active_c  = 0;
        granted_c = 0;
        for (int i = 0; i < ZONES; i++) begin
            if (state_q[i] == ST_WATER) active_c = active_c + 1;
        end
        // Slots are judged on the registered WATER count, so a zone leaving
        // WATER this cycle does not free its slot until the next one.
        for (int i = 0; i < ZONES; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                ST_IDLE: begin
                    if (enable[i] && (sens[i] < LOW_V) &&
                        ((active_c + granted_c) < MAX_ACTIVE)) begin
                        granted_c  = granted_c + 1;
                        state_d[i] = ST_WATER;
                        cnt_d[i]   = '0;
                    end
                end
                ST_WATER: begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                    if (!enable[i]) begin
                        state_d[i] = ST_COOL;
                        cnt_d[i]   = '0;
                    end else if ((cnt_q[i] == MAX_LAST) && (sens[i] < HIGH_V)) begin
                        state_d[i] = ST_FAULT;
                        cnt_d[i]   = '0;
                    end else if ((cnt_q[i] >= MIN_LAST) && (sens[i] >= HIGH_V)) begin
                        state_d[i] = ST_COOL;
                        cnt_d[i]   = '0;
                    end
                end
                ST_COOL: begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                    if (cnt_q[i] == COOL_LAST) begin
                        state_d[i] = ST_IDLE;
                        cnt_d[i]   = '0;
                    end
                end
                default: begin
                    if (!enable[i]) state_d[i] = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < ZONES; i++) begin
            if (reset) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
            end else begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

endmodule
